// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio DC-blocker datapath.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {IDLE, CH_L, CH_R, EMIT} state_t;

    typedef struct packed {
        logic    ovf;
        sample_t val;
    } sat_t;

    // Clamp a wide signed value into the 16-bit sample range, flagging overflow.
    function automatic sat_t sat16(input logic signed [31:0] acc);
        sat_t r;
        if (acc > 32'sd32767) begin
            r.ovf = 1'b1;
            r.val = 16'sh7FFF;
        end else if (acc < -32'sd32768) begin
            r.ovf = 1'b1;
            r.val = 16'sh8000;
        end else begin
            r.ovf = 1'b0;
            r.val = acc[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dc_block_step.sv
// One step of the first-order DC-blocking high-pass IIR, purely combinational.
module dc_block_step
    import audio_pkg::*;
#(
    parameter int K    = 10,
    parameter int FRAC = 8
) (
    input  sample_t                          x,
    input  sample_t                          x_prev,
    input  logic signed [SAMPLE_W+FRAC+1:0]  acc,
    output logic signed [SAMPLE_W+FRAC+1:0]  acc_next,
    output sample_t                          y,
    output logic                             sat
);

    localparam int W = SAMPLE_W + FRAC + 2;

    logic signed [SAMPLE_W:0]   d;
    logic signed [W-1:0]        d_scaled;
    logic signed [W-FRAC-1:0]   y_wide;
    sat_t                       y_sat;

    // The 17-bit difference of two sign-extended samples can never wrap.
    assign d        = {x[SAMPLE_W-1], x} - {x_prev[SAMPLE_W-1], x_prev};
    assign d_scaled = W'(d) <<< FRAC;
    assign acc_next = acc + d_scaled - (acc >>> K);
    assign y_wide   = acc_next[W-1:FRAC];
    assign y_sat    = sat16(32'(y_wide));
    assign y        = y_sat.val;
    assign sat      = y_sat.ovf;

endmodule

// File: rtl/audio_dc_blocker.sv
// Decimating stereo DC blocker: divider strobe, shared IIR step sequenced L then R, saturating output.
module audio_dc_blocker
    import audio_pkg::*;
#(
    parameter int DIV  = 447,
    parameter int K    = 10,
    parameter int FRAC = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        bypass,
    input  logic        mute,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    output logic        clip
);

    localparam int          ACC_W    = SAMPLE_W + FRAC + 2;
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0]             cnt_q, cnt_d;
    state_t                  state_q, state_d;
    sample_t                 xl_q, xl_d, xr_q, xr_d;
    sample_t                 xp_l_q, xp_l_d, xp_r_q, xp_r_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    sample_t                 y_l_q, y_l_d, y_r_q, y_r_d;
    sample_t                 out_l_q, out_l_d, out_r_q, out_r_d;
    logic                    valid_q, valid_d;
    logic                    clip_q, clip_d;
    logic                    strobe;

    logic                    use_r;
    sample_t                 step_x, step_xp, step_y, step_out;
    logic signed [ACC_W-1:0] step_acc, step_acc_next;
    logic                    step_sat;

    // Operand muxing stays outside the FSM block so the shared step is not a combinational loop.
    assign use_r    = (state_q == CH_R);
    assign step_x   = use_r ? xr_q   : xl_q;
    assign step_xp  = use_r ? xp_r_q : xp_l_q;
    assign step_acc = use_r ? acc_r_q : acc_l_q;
    assign step_out = mute ? '0 : (bypass ? step_x : step_y);

    dc_block_step #(.K(K), .FRAC(FRAC)) u_step (
        .x        (step_x),
        .x_prev   (step_xp),
        .acc      (step_acc),
        .acc_next (step_acc_next),
        .y        (step_y),
        .sat      (step_sat)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        strobe  = (cnt_q == DIV_LAST);
        cnt_d   = strobe ? '0 : cnt_q + 16'd1;
        state_d = state_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        xp_l_d  = xp_l_q;
        xp_r_d  = xp_r_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        y_l_d   = y_l_q;
        y_r_d   = y_r_q;
        out_l_d = out_l_q;
        out_r_d = out_r_q;
        valid_d = 1'b0;
        clip_d  = clip_q;

        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    xl_d    = in_l ^ 16'h8000;
                    xr_d    = in_r ^ 16'h8000;
                    state_d = CH_L;
                end
            end
            CH_L: begin
                acc_l_d = step_acc_next;
                xp_l_d  = xl_q;
                y_l_d   = step_out;
                clip_d  = clip_q | step_sat;
                state_d = CH_R;
            end
            CH_R: begin
                acc_r_d = step_acc_next;
                xp_r_d  = xr_q;
                y_r_d   = step_out;
                clip_d  = clip_q | step_sat;
                state_d = EMIT;
            end
            EMIT: begin
                out_l_d = y_l_q;
                out_r_d = y_r_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
        if (!reset_n) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            xl_q    <= '0;
            xr_q    <= '0;
            xp_l_q  <= '0;
            xp_r_q  <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            y_l_q   <= '0;
            y_r_q   <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            xp_l_q  <= xp_l_d;
            xp_r_q  <= xp_r_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            y_l_q   <= y_l_d;
            y_r_q   <= y_r_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = valid_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_audio_dc_blocker.sv
// Directed bench for audio_dc_blocker (DIV = 8) with hand-computed expectations.
module tb_audio_dc_blocker;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_l    = 16'h8000;
    logic [15:0] in_r    = 16'h8000;
    logic        bypass  = 1'b0;
    logic        mute    = 1'b0;
    logic [15:0] out_l, out_r;
    logic        out_valid, clip;

    int checks   = 0;
    int failures = 0;

    audio_dc_blocker #(.DIV(8), .K(10), .FRAC(8)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .in_l      (in_l),
        .in_r      (in_r),
        .bypass    (bypass),
        .mute      (mute),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .clip      (clip)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // Counts rising edges until out_valid is seen high on a falling edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk_sys);
            n++;
            @(negedge clk_sys);
            if (out_valid) return;
        end
        check("valid_timeout", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    logic [15:0] mute_vec [4] = '{16'h0000, 16'hFFFF, 16'h1234, 16'hC000};

    initial begin
        int n;
        int prev, viol, r_nz, gap_bad;

        // Reset state and silence
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_out_l", out_l, 16'h0000);
        check("rst_out_r", out_r, 16'h0000);
        check("rst_valid", out_valid, 1'b0);
        check("rst_clip", clip, 1'b0);
        reset_n = 1'b1;
        wait_valid(n);
        check("first_latency", n, 11);
        check("silence_l", out_l, 16'h0000);
        check("silence_r", out_r, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            check("silence_gap", n, 8);
            check("silence_l_n", out_l, 16'h0000);
        end
        check("silence_clip", clip, 1'b0);

        // Step +16384 on left, then exponential decay
        in_l = 16'hC000;
        wait_valid(n);
        check("step_y0", out_l, 16'd16384);
        check("step_r0", out_r, 16'h0000);
        wait_valid(n);
        check("step_y1", out_l, 16'd16368);
        wait_valid(n);
        check("step_y2", out_l, 16'd16352);
        prev = 16352; viol = 0; r_nz = 0; gap_bad = 0;
        for (int i = 0; i < 1100; i++) begin
            wait_valid(n);
            if (n != 8) gap_bad++;
            if (int'($signed(out_l)) > prev) viol++;
            prev = int'($signed(out_l));
            if (out_r != 16'h0000) r_nz++;
        end
        check("decay_monotonic", viol, 0);
        check("decay_r_zero", r_nz, 0);
        check("decay_gap", gap_bad, 0);
        check("decay_below_e1", (prev < 6027 && prev > 0), 1'b1);
        check("decay_no_clip", clip, 1'b0);

        // Full-scale step saturates and sets sticky clip
        in_l = 16'h0000;
        apply_reset();
        wait_valid(n);
        check("neg_y0", out_l, 16'h8000);
        check("neg_clip0", clip, 1'b0);
        wait_valid(n);
        check("neg_y1", out_l, 16'h8020);
        check("neg_clip1", clip, 1'b0);
        in_l = 16'hFFFF;
        wait_valid(n);
        check("sat_y", out_l, 16'h7FFF);
        check("sat_clip", clip, 1'b1);
        check("sat_r", out_r, 16'h0000);
        repeat (20) wait_valid(n);
        check("clip_sticky", clip, 1'b1);

        // Bypass passes the MSB-inverted input with unchanged latency
        in_l   = 16'h1234;
        bypass = 1'b1;
        apply_reset();
        wait_valid(n);
        check("bypass_latency", n, 11);
        check("bypass_l", out_l, 16'h9234);
        check("bypass_r", out_r, 16'h0000);
        check("bypass_clip_cleared", clip, 1'b0);

        // Reset on the CH_R edge of the next sequence aborts it
        repeat (6) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        check("abort_l", out_l, 16'h0000);
        check("abort_r", out_r, 16'h0000);
        check("abort_valid", out_valid, 1'b0);
        wait_valid(n);
        check("abort_next_latency", n, 11);
        check("abort_next_l", out_l, 16'h9234);

        // Mute forces zero while the input varies
        bypass = 1'b0;
        mute   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_l = mute_vec[i];
            in_r = mute_vec[3 - i];
            wait_valid(n);
            check("mute_gap", n, 8);
            check("mute_l", out_l, 16'h0000);
            check("mute_r", out_r, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
